// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-adder, instruction-memory and decode signals of pc_sequencer.
// master = sequencer side, slave = the surrounding fetch/memory/decode logic.
interface pc_sequencer_if;
    logic [31:0] pc_out;
    logic [31:0] constant_4;
    logic [31:0] adder_pc_4;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        align_err;
    modport master (
        output pc_out, constant_4, imem_req, imem_addr, instr_out, instr_valid, align_err,
        input  adder_pc_4, branch_taken, branch_target, jump, jump_target, imem_ack, imem_rdata, instr_ready
    );
    modport slave (
        input  pc_out, constant_4, imem_req, imem_addr, instr_out, instr_valid, align_err,
        output adder_pc_4, branch_taken, branch_target, jump, jump_target, imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, sequences imem req/ack and decode valid/ready, applies redirects.
// Optional PC_ALIGN_CHECK_EN: force redirect targets word-aligned and raise sticky align_err.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INCR     = 32'd4
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.master io_seq
);
    typedef enum logic [1:0] {S_SETTLE, S_REQ, S_OUT} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_instr, r_pend_tgt;
    logic [31:0] w_raw_tgt, w_tgt_in, w_tgt, w_pc_next;
    logic        r_pend, w_redir, w_have, w_pc_load, w_capture;

    assign w_redir   = io_seq.jump | io_seq.branch_taken;
    assign w_raw_tgt = io_seq.jump ? io_seq.jump_target : io_seq.branch_target;
`ifdef PC_ALIGN_CHECK_EN
    logic r_align_err;
    assign w_tgt_in         = {w_raw_tgt[31:2], 2'b00};
    assign io_seq.align_err = r_align_err;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_align_err <= 1'b0;
        else if (w_redir && (|w_raw_tgt[1:0])) r_align_err <= 1'b1;
    end
`else
    assign w_tgt_in         = w_raw_tgt;
    assign io_seq.align_err = 1'b0;
`endif
    // a pulse arriving this cycle is newer than anything already pending
    assign w_have = w_redir | r_pend;
    assign w_tgt  = w_redir ? w_tgt_in : r_pend_tgt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_SETTLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next             = r_state;
        w_pc_load          = 1'b0;
        w_capture          = 1'b0;
        w_pc_next          = w_tgt;
        io_seq.imem_req    = 1'b0;
        io_seq.instr_valid = 1'b0;
        case (r_state)
            S_SETTLE: w_next = S_REQ;
            S_REQ: begin
                io_seq.imem_req = 1'b1;
                if (io_seq.imem_ack) begin
                    w_next    = w_have ? S_SETTLE : S_OUT;
                    w_pc_load = w_have;
                    w_capture = !w_have;
                end
            end
            S_OUT: begin
                io_seq.instr_valid = 1'b1;
                if (io_seq.instr_ready) begin
                    w_next    = S_SETTLE;
                    w_pc_load = 1'b1;
                    w_pc_next = w_have ? w_tgt : io_seq.adder_pc_4;
                end
            end
            default: w_next = S_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_pend     <= 1'b0;
            r_pend_tgt <= '0;
        end else begin
            if (w_pc_load) r_pc <= w_pc_next;
            if (w_capture) r_instr <= io_seq.imem_rdata;
            if (w_pc_load) r_pend <= 1'b0;
            else if (w_redir) begin
                r_pend     <= 1'b1;
                r_pend_tgt <= w_tgt_in;
            end
        end
    end

    assign io_seq.pc_out     = r_pc;
    assign io_seq.imem_addr  = r_pc;
    assign io_seq.instr_out  = r_instr;
    assign io_seq.constant_4 = INCR;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios plus randomized traffic checked against a
// transaction-level model of the fetch sequence (PC, pending redirect, held word).
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] INC    = 32'd4;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_sequencer_if bus ();
    pc_sequencer #(.RESET_PC(RST_PC), .INCR(INC)) dut (.clk(clk), .rst(rst), .io_seq(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h8C01_0004;
    endfunction

    function automatic logic [31:0] fix_tgt(input logic [31:0] t);
        return ALIGN_ON ? {t[31:2], 2'b00} : t;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);
    always @(posedge clk) bus.adder_pc_4 <= bus.pc_out + bus.constant_4;

    // model: predicts the visible state after the coming rising edge
    logic [31:0] m_pc, m_ptgt, m_word;
    logic        m_pend, m_req, m_has, m_align;
    always @(negedge clk) begin
        logic [31:0] pc, ptgt, word, tgt;
        logic        pend, req, has, al, redir;
        pc = m_pc; ptgt = m_ptgt; word = m_word; pend = m_pend; req = m_req; has = m_has; al = m_align;
        if (!rst) begin
            pc = RST_PC; ptgt = 0; word = 0; pend = 0; req = 0; has = 0; al = 0;
        end else begin
            redir = bus.jump | bus.branch_taken;
            tgt   = bus.jump ? bus.jump_target : bus.branch_target;
            if (redir) begin
                pend = 1; ptgt = fix_tgt(tgt);
                if (ALIGN_ON && tgt[1:0] != 2'b00) al = 1;
            end
            if (req && bus.imem_ack) begin
                req = 0;
                if (pend) begin pc = ptgt; pend = 0; end
                else begin word = mem_word(pc); has = 1; end
            end else if (has && bus.instr_ready) begin
                has = 0;
                pc = pend ? ptgt : pc + INC;
                pend = 0;
            end else if (!has) req = 1;
        end
        m_pc <= pc; m_ptgt <= ptgt; m_word <= word; m_pend <= pend; m_req <= req; m_has <= has; m_align <= al;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        bus.branch_taken = 0; bus.jump = 0; bus.branch_target = 0; bus.jump_target = 0;
    endtask

    task automatic do_reset;
        rst = 0;
        quiet();
        bus.imem_ack = 0;
        bus.instr_ready = 0;
        step();
        step();
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++;
        if ({bus.pc_out, bus.instr_out, bus.instr_valid, bus.imem_req, bus.align_err} !== {RST_PC, 32'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state: got pc=%h instr=%h v=%b req=%b aerr=%b want pc=%h instr=0 v=0 req=0 aerr=0",
                     bus.pc_out, bus.instr_out, bus.instr_valid, bus.imem_req, bus.align_err, RST_PC);
        end
        n_cmp++;
        if (bus.constant_4 !== INC) begin
            n_bad++;
            $display("FAIL constant_4: got %h want %h", bus.constant_4, INC);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] seen[$];
        rst = 1; bus.imem_ack = 1; bus.instr_ready = 1;
        for (int i = 0; i < 9; i++) begin
            step();
            n_cmp++;
            if ({bus.pc_out, bus.imem_addr, bus.imem_req, bus.instr_valid} !== {m_pc, m_pc, m_req, m_has}) begin
                n_bad++;
                $display("FAIL seq_cycle%0d: got pc=%h addr=%h req=%b v=%b want pc=%h req=%b v=%b",
                         i, bus.pc_out, bus.imem_addr, bus.imem_req, bus.instr_valid, m_pc, m_req, m_has);
            end
            if (bus.instr_valid === 1'b1) seen.push_back(bus.pc_out);
        end
        n_cmp++;
        if (seen.size() != 3) begin
            n_bad++;
            $display("FAIL seq_count: got %0d instructions in 9 cycles want 3", seen.size());
        end else
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (seen[i] !== 32'(4 * i)) begin
                    n_bad++;
                    $display("FAIL seq_pc%0d: got %h want %h", i, seen[i], 32'(4 * i));
                end
            end
    endtask

    task automatic test_ack_delay;
        int req_cycles = 0;
        do_reset();
        rst = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({bus.imem_req, bus.instr_valid, bus.pc_out} !== {2'b10, 32'h0}) begin
                n_bad++;
                $display("FAIL ack_wait%0d: got req=%b v=%b pc=%h want req=1 v=0 pc=0", i, bus.imem_req, bus.instr_valid, bus.pc_out);
            end
            if (bus.imem_req === 1'b1) req_cycles++;
            step();
        end
        if (bus.imem_req === 1'b1) req_cycles++;
        bus.imem_ack = 1;
        step();
        bus.imem_ack = 0;
        n_cmp++;
        if (req_cycles != 6) begin
            n_bad++;
            $display("FAIL ack_req_len: got %0d req cycles want 6", req_cycles);
        end
        n_cmp++;
        if ({bus.instr_valid, bus.imem_req, bus.pc_out} !== {2'b10, 32'h0}) begin
            n_bad++;
            $display("FAIL ack_valid: got v=%b req=%b pc=%h want v=1 req=0 pc=0", bus.instr_valid, bus.imem_req, bus.pc_out);
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({bus.instr_valid, bus.instr_out, bus.pc_out} !== {1'b1, 32'h8C01_0004, 32'h0}) begin
                n_bad++;
                $display("FAIL stall%0d: got v=%b instr=%h pc=%h want v=1 instr=8c010004 pc=0", i, bus.instr_valid, bus.instr_out, bus.pc_out);
            end
            step();
        end
        bus.instr_ready = 1;
        step();
        n_cmp++;
        if ({bus.pc_out, bus.instr_valid} !== {32'h4, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_release: got pc=%h v=%b want pc=4 v=0", bus.pc_out, bus.instr_valid);
        end
    endtask

    task automatic test_branch_squash;
        bit found = 0;
        bus.imem_ack = 1; bus.instr_ready = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.pc_out === 32'h8 && !bus.imem_req && !bus.instr_valid) found = 1;
            else step();
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL squash_reach: got pc=%h, settle at pc 8 not reached within 20 cycles", bus.pc_out);
        end
        bus.imem_ack = 0;
        step();
        bus.branch_taken = 1; bus.branch_target = 32'h40;
        step();
        quiet();
        step();
        bus.imem_ack = 1;
        n_cmp++;
        if ({bus.imem_req, bus.instr_valid, bus.pc_out} !== {2'b10, 32'h8}) begin
            n_bad++;
            $display("FAIL squash_req: got req=%b v=%b pc=%h want req=1 v=0 pc=8", bus.imem_req, bus.instr_valid, bus.pc_out);
        end
        step();
        bus.imem_ack = 0;
        n_cmp++;
        if ({bus.instr_valid, bus.pc_out} !== {1'b0, 32'h40}) begin
            n_bad++;
            $display("FAIL squash_pc: got v=%b pc=%h want v=0 pc=40", bus.instr_valid, bus.pc_out);
        end
        step();
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h40, 1'b0}) begin
            n_bad++;
            $display("FAIL squash_addr: got req=%b addr=%h v=%b want req=1 addr=40 v=0", bus.imem_req, bus.imem_addr, bus.instr_valid);
        end
    endtask

    task automatic test_jump_priority;
        bus.imem_ack = 1; bus.instr_ready = 1;
        step();
        bus.imem_ack = 0;
        n_cmp++;
        if ({bus.instr_valid, bus.instr_out} !== {1'b1, mem_word(32'h40)}) begin
            n_bad++;
            $display("FAIL jmp_present: got v=%b instr=%h want v=1 instr=%h", bus.instr_valid, bus.instr_out, mem_word(32'h40));
        end
        bus.jump = 1; bus.jump_target = 32'h100; bus.branch_taken = 1; bus.branch_target = 32'h40;
        step();
        quiet();
        n_cmp++;
        if ({bus.pc_out, bus.instr_valid} !== {32'h100, 1'b0}) begin
            n_bad++;
            $display("FAIL jmp_priority: got pc=%h v=%b want pc=100 v=0", bus.pc_out, bus.instr_valid);
        end
    endtask

    task automatic test_align;
        logic [31:0] want_pc = ALIGN_ON ? 32'h100 : 32'h102;
        bus.jump = 1; bus.jump_target = 32'h102;
        step();
        quiet();
        bus.imem_ack = 1;
        step();
        bus.imem_ack = 0;
        n_cmp++;
        if ({bus.pc_out, bus.align_err} !== {want_pc, ALIGN_ON}) begin
            n_bad++;
            $display("FAIL align_load: got pc=%h aerr=%b want pc=%h aerr=%b", bus.pc_out, bus.align_err, want_pc, ALIGN_ON);
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (bus.align_err !== ALIGN_ON) begin
            n_bad++;
            $display("FAIL align_hold: got %b want %b", bus.align_err, ALIGN_ON);
        end
        do_reset();
        n_cmp++;
        if (bus.align_err !== 1'b0) begin
            n_bad++;
            $display("FAIL align_clear: got %b want 0", bus.align_err);
        end
    endtask

    task automatic test_reset_midfetch;
        rst = 1; bus.imem_ack = 0; bus.instr_ready = 1;
        step();
        step();
        bus.imem_ack = 1;
        #2 rst = 0;
        #1;
        n_cmp++;
        if ({bus.imem_req, bus.instr_valid, bus.pc_out} !== {2'b00, RST_PC}) begin
            n_bad++;
            $display("FAIL async_reset: got req=%b v=%b pc=%h want req=0 v=0 pc=%h", bus.imem_req, bus.instr_valid, bus.pc_out, RST_PC);
        end
        step();
        rst = 1;
        step();
        n_cmp++;
        if ({bus.imem_req, bus.instr_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_ack_ignored: got req=%b v=%b want req=1 v=0", bus.imem_req, bus.instr_valid);
        end
        bus.imem_ack = 0;
    endtask

    task automatic test_random;
        logic [31:0] prev_pc;
        int          acc = 0;
        int          r;
        do_reset();
        rst = 1;
        prev_pc = bus.pc_out;
        for (int i = 0; i < 800; i++) begin
            step();
            n_cmp++;
            if ({bus.pc_out, bus.imem_addr, bus.imem_req, bus.instr_valid, bus.align_err} !== {m_pc, m_pc, m_req, m_has, m_align}) begin
                n_bad++;
                $display("FAIL rnd_ctrl@%0d: got pc=%h addr=%h req=%b v=%b aerr=%b want pc=%h req=%b v=%b aerr=%b",
                         i, bus.pc_out, bus.imem_addr, bus.imem_req, bus.instr_valid, bus.align_err, m_pc, m_req, m_has, m_align);
            end
            n_cmp++;
            if (bus.instr_out !== m_word) begin
                n_bad++;
                $display("FAIL rnd_instr@%0d: got %h want %h", i, bus.instr_out, m_word);
            end
            if (bus.pc_out !== prev_pc) begin
                n_cmp++;
                if (bus.imem_req !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rnd_req_after_pc@%0d: got req=%b want 0", i, bus.imem_req);
                end
            end
            prev_pc = bus.pc_out;
            if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) acc++;
            bus.imem_ack     = ($urandom % 2) == 0;
            bus.instr_ready  = ($urandom % 5) < 3;
            r                = int'($urandom % 100);
            bus.branch_taken = r < 10;
            bus.jump         = r >= 6 && r < 13;
            bus.branch_target = ($urandom & 32'h0000_0FFC) | (($urandom % 8) == 0 ? 32'h2 : 32'h0);
            bus.jump_target   = ($urandom & 32'h0000_FFFC) | (($urandom % 8) == 0 ? 32'h1 : 32'h0);
            rst = ($urandom % 150) != 0;
        end
        rst = 1;
        n_cmp++;
        if (acc < 20) begin
            n_bad++;
            $display("FAIL rnd_progress: got %0d accepted instructions want at least 20", acc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_stall();
        test_branch_squash();
        test_jump_priority();
        test_align();
        test_reset_midfetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
